// File: rtl/dot_mac_sequencer.sv
// Operand sequencer for the dual-product MAC (a*c + b*d): gathers four operand
// words, runs the MAC under a bounded wait, and hands the result downstream.
module dot_mac_sequencer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_mode,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [31:0] op_c,
    output logic [31:0] op_d,
    output logic [3:0]  mac_ctrl,
    input  logic [1:0]  mac_status,
    input  logic [31:0] mac_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err
);

    localparam int unsigned DW = 32;
    localparam logic [1:0]  MODE_RSVD   = 2'b10;
    localparam logic [1:0]  STAT_DONE   = 2'b11;
    localparam logic [CW-1:0] WCNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] WCNT_SAT  = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_WAIT    = 2'd1,
        S_OUT     = 2'd2
    } state_t;

    state_t          state_q,     state_d;
    logic [1:0]      cnt_q,       cnt_d;
    logic [CW-1:0]   wcnt_q,      wcnt_d;
    logic [1:0]      mode_q,      mode_d;
    logic [DW-1:0]   op_a_q,      op_a_d;
    logic [DW-1:0]   op_b_q,      op_b_d;
    logic [DW-1:0]   op_c_q,      op_c_d;
    logic [DW-1:0]   op_d_q,      op_d_d;
    logic [3:0]      mac_ctrl_q,  mac_ctrl_d;
    logic            in_ready_q,  in_ready_d;
    logic            res_valid_q, res_valid_d;
    logic [DW-1:0]   res_data_q,  res_data_d;
    logic            res_err_q,   res_err_d;

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wcnt_d      = wcnt_q;
        mode_d      = mode_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_c_d      = op_c_q;
        op_d_d      = op_d_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;

        case (state_q)
            S_COLLECT: begin
                if (in_valid && in_ready_q) begin
                    cnt_d = cnt_q + 2'd1;
                    case (cnt_q)
                        2'd0: begin
                            op_a_d = in_data;
                            mode_d = in_mode;
                        end
                        2'd1:    op_b_d = in_data;
                        2'd2:    op_c_d = in_data;
                        default: op_d_d = in_data;
                    endcase
                    if (cnt_q == 2'd3) begin
                        cnt_d = 2'd0;
                        // Reserved precision never reaches the MAC
                        if (mode_q == MODE_RSVD) begin
                            state_d     = S_OUT;
                            res_valid_d = 1'b1;
                            res_data_d  = '0;
                            res_err_d   = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                            wcnt_d  = '0;
                        end
                    end
                end
            end
            S_WAIT: begin
                wcnt_d = (wcnt_q == WCNT_SAT) ? wcnt_q : wcnt_q + CW'(1);
                // A done status on the timeout cycle still counts as success
                if (mac_status == STAT_DONE) begin
                    state_d     = S_OUT;
                    res_valid_d = 1'b1;
                    res_data_d  = mac_result;
                    res_err_d   = 1'b0;
                end else if (wcnt_q == WCNT_LAST) begin
                    state_d     = S_OUT;
                    res_valid_d = 1'b1;
                    res_data_d  = '0;
                    res_err_d   = 1'b1;
                end
            end
            S_OUT: begin
                if (res_valid_q && res_ready) begin
                    state_d     = S_COLLECT;
                    res_valid_d = 1'b0;
                    cnt_d       = 2'd0;
                end
            end
            default: begin
                state_d = S_COLLECT;
                cnt_d   = 2'd0;
            end
        endcase

        in_ready_d = (state_d == S_COLLECT);
        mac_ctrl_d = {(state_d == S_WAIT), 1'b1, mode_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_COLLECT;
            cnt_q       <= 2'd0;
            wcnt_q      <= '0;
            mode_q      <= 2'b00;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_c_q      <= '0;
            op_d_q      <= '0;
            mac_ctrl_q  <= 4'b0000;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            mode_q      <= mode_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_c_q      <= op_c_d;
            op_d_q      <= op_d_d;
            mac_ctrl_q  <= mac_ctrl_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_c      = op_c_q;
    assign op_d      = op_d_q;
    assign mac_ctrl  = mac_ctrl_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_dot_mac_sequencer.sv
// Directed scoreboard bench for dot_mac_sequencer with a behavioural MAC.
module tb_dot_mac_sequencer;

    localparam int unsigned TIMEOUT = 16;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_mode;
    logic [31:0] op_a, op_b, op_c, op_d;
    logic [3:0]  mac_ctrl;
    logic [1:0]  mac_status;
    logic [31:0] mac_result;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_err;
    logic        mac_dead;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb[$];

    dot_mac_sequencer #(.TIMEOUT(TIMEOUT), .CW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
        .mac_ctrl(mac_ctrl), .mac_status(mac_status), .mac_result(mac_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mac_fn(input logic [31:0] a, b, c, d, input logic [1:0] m);
        logic [31:0] mask;
        case (m)
            2'b00:   mask = 32'h0000_000F;
            2'b01:   mask = 32'h0000_00FF;
            default: mask = 32'h0000_FFFF;
        endcase
        return ((a & mask) * (c & mask)) + ((b & mask) * (d & mask));
    endfunction

    // MAC: one cycle to compute once enabled, status cleared when disabled
    always @(posedge clk) begin
        if (!mac_ctrl[2]) begin
            mac_status <= 2'b00;
            mac_result <= 32'd0;
        end else if (mac_ctrl[3] && !mac_dead) begin
            mac_status <= 2'b11;
            mac_result <= mac_fn(op_a, op_b, op_c, op_d, mac_ctrl[1:0]);
        end else if (!mac_ctrl[3]) begin
            mac_status <= 2'b00;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic [1:0] m);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        in_mode  = m;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_collect", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] w0, w1, w2, w3, input logic [1:0] m,
                          input int exp_lat, input logic [3:0] exp_ctrl, input int hold);
        exp_t e;
        exp_t got;
        int   n;
        if (m == 2'b10 || mac_dead) e = '{err: 1'b1, data: 32'd0};
        else                        e = '{err: 1'b0, data: mac_fn(w0, w1, w2, w3, m)};
        sb.push_back(e);
        send_word(w0, m);
        send_word(w1, m);
        send_word(w2, m);
        send_word(w3, m);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk("mac_ctrl_first", 32'(mac_ctrl), 32'(exp_ctrl));
        end while (!res_valid && n < 100);
        chk("latency", 32'(n), 32'(exp_lat));
        got = sb.pop_front();
        chk("res_data", res_data, got.data);
        chk("res_err", 32'(res_err), 32'(got.err));
        chk("in_ready_out", 32'(in_ready), 32'd0);
        chk("enable_out", 32'(mac_ctrl[3]), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_data", res_data, got.data);
            chk("hold_err", 32'(res_err), 32'(got.err));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("valid_cleared", 32'(res_valid), 32'd0);
        chk("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_op_a"}, op_a, 32'd0);
        chk({tag, "_op_b"}, op_b, 32'd0);
        chk({tag, "_op_c"}, op_c, 32'd0);
        chk({tag, "_op_d"}, op_d, 32'd0);
        chk({tag, "_ctrl"}, 32'(mac_ctrl), 32'd0);
        chk({tag, "_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_data"}, res_data, 32'd0);
        chk({tag, "_err"}, 32'(res_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_mode   = 2'b00;
        res_ready = 1'b1;
        mac_dead  = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ctrl_after_reset", 32'(mac_ctrl), 32'h4);
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);

        // Nominal ops in 4-bit and 16-bit precision
        run_op(32'd3, 32'd5, 32'd7, 32'd2, 2'b00, 3, 4'b1100, 0);
        run_op(32'hFFFF, 32'd1, 32'hFFFF, 32'd1, 2'b11, 3, 4'b1111, 0);
        chk("mode11_value", 32'(mac_fn(32'hFFFF, 32'd1, 32'hFFFF, 32'd1, 2'b11)), 32'hFFFE_0002);

        // Reserved mode bypasses the MAC
        run_op(32'd11, 32'd22, 32'd33, 32'd44, 2'b10, 1, 4'b0110, 0);

        // MAC never completes
        mac_dead = 1'b1;
        run_op(32'd1, 32'd2, 32'd3, 32'd4, 2'b01, TIMEOUT + 1, 4'b1101, 0);
        mac_dead = 1'b0;

        // Downstream back-pressure, then back-to-back operation
        res_ready = 1'b0;
        run_op(32'd10, 32'd20, 32'd30, 32'd40, 2'b01, 3, 4'b1101, 5);
        run_op(32'd15, 32'd15, 32'd15, 32'd15, 2'b00, 3, 4'b1100, 0);

        // Reset while waiting on the MAC
        mac_dead = 1'b1;
        send_word(32'd7, 2'b00);
        send_word(32'd7, 2'b00);
        send_word(32'd7, 2'b00);
        send_word(32'd7, 2'b00);
        repeat (3) @(negedge clk);
        chk("enable_in_wait", 32'(mac_ctrl[3]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_wait");
        @(negedge clk);
        rst_n    = 1'b1;
        mac_dead = 1'b0;
        @(negedge clk);
        run_op(32'd2, 32'd3, 32'd4, 32'd5, 2'b00, 3, 4'b1100, 0);

        // Reset after two operand words
        send_word(32'd9, 2'b11);
        send_word(32'd9, 2'b11);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_collect");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(32'd1, 32'd2, 32'd3, 32'd4, 2'b00, 3, 4'b1100, 0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
